// File: rtl/rf_writeback_scoreboard.sv
// rf_writeback_scoreboard
//   Writer side of the register file. Holds the MEM/WB pipeline register that
//   drives the RF write port and keeps a per-register count of in-flight writes.
//   From those counts it raises a read-after-write STALL towards decode.
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   ISSUE_VALID/WE/WA     instruction presented by decode and its destination
//   SRC_RA1, SRC_RA2      source registers of the issuing instruction
//   STALL                 combinational hold request to decode
//   MEM_*                 memory-stage result, kill flag and destination
//   RFWE, RFWA, RFWD      registered RF write port (one cycle after MEM)
//
// Parameters
//   PEND_W  width of each pending-write counter (saturates at 2^PEND_W-1)
//   NREG    number of architectural registers (r0 reads as zero); the port
//           address width fixes NREG <= 32
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a source whose only pending write is committing this cycle
//   does not stall; the RF write-through provides the value.
module rf_writeback_scoreboard #(
    parameter int PEND_W = 2,
    parameter int NREG   = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ISSUE_VALID,
    input  logic        ISSUE_WE,
    input  logic [4:0]  ISSUE_WA,
    input  logic [4:0]  SRC_RA1,
    input  logic [4:0]  SRC_RA2,
    output logic        STALL,
    input  logic        MEM_VALID,
    input  logic        MEM_KILL,
    input  logic        MEM_RFWE,
    input  logic        MEM_MEMTOREG,
    input  logic [4:0]  MEM_WA,
    input  logic [31:0] MEM_ALUOUT,
    input  logic [31:0] MEM_RDATA,
    output logic        RFWE,
    output logic [4:0]  RFWA,
    output logic [31:0] RFWD
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] cnt_q [NREG];
    logic [PEND_W-1:0] cnt_d [NREG];

    // WB slot holds a register-writing instruction, killed or not; it retires
    // one pending count even when RFWE is suppressed by the kill.
    logic ret_q;

    logic busy1, busy2, sat;
    logic accept, retire;
    logic inc, dec;

    // A source is busy while it has any pending write. With the bypass, the
    // last pending write committing right now is served by write-through.
    function automatic logic src_busy(input logic [4:0]        r,
                                      input logic [PEND_W-1:0] c,
                                      input logic              we,
                                      input logic [4:0]        wa);
        logic b;
        b = (r != '0) && (c != '0);
`ifdef WB_BYPASS_EN
        if (we && (wa == r) && (c == CNT_ONE))
            b = 1'b0;
`else
        if (we && (wa == r) && (c == '0))
            b = 1'b0;
`endif
        return b;
    endfunction

    // Counters are cleared asynchronously, so STALL is already 0 during reset.
    always_comb begin
        busy1 = src_busy(SRC_RA1, cnt_q[SRC_RA1], RFWE, RFWA);
        busy2 = src_busy(SRC_RA2, cnt_q[SRC_RA2], RFWE, RFWA);
        sat   = ISSUE_WE && (cnt_q[ISSUE_WA] == CNT_MAX);
        STALL = ISSUE_VALID && (busy1 || busy2 || sat);
    end

    assign accept = ISSUE_VALID & ~STALL & ISSUE_WE & (ISSUE_WA != '0);
    assign retire = ret_q & (RFWA != '0);

    // Accept and retire to the same register cancel out. A retire with the
    // counter at zero is a protocol error; the counter holds at zero.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            inc      = accept && (ISSUE_WA == 5'(r));
            dec      = retire && (RFWA == 5'(r));
            if (r == 0)
                cnt_d[r] = '0;
            else if (inc && !dec)
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            else if (dec && !inc && (cnt_q[r] != '0))
                cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RFWE  <= 1'b0;
            RFWA  <= '0;
            RFWD  <= '0;
            ret_q <= 1'b0;
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
        end else begin
            RFWE  <= MEM_VALID & MEM_RFWE & ~MEM_KILL & (MEM_WA != '0);
            RFWA  <= MEM_WA;
            RFWD  <= MEM_MEMTOREG ? MEM_RDATA : MEM_ALUOUT;
            ret_q <= MEM_VALID & MEM_RFWE;
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST)
            assert (!(retire && (cnt_q[RFWA] == '0)))
            else $error("rf_writeback_scoreboard: retire of r%0d with no pending write", RFWA);
    end
`endif

endmodule

// File: tb/tb_rf_writeback_scoreboard.sv
// tb_rf_writeback_scoreboard
//   Self-checking bench for rf_writeback_scoreboard: a table of WB datapath
//   vectors, hand-written multi-cycle sequences (reset, RAW, r0, kill,
//   saturation) and a randomized phase checked against a pending-count model.
module tb_rf_writeback_scoreboard;

    localparam int PEND_W = 2;
    localparam int CMAX   = (1 << PEND_W) - 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK, RST;
    logic        ISSUE_VALID, ISSUE_WE;
    logic [4:0]  ISSUE_WA, SRC_RA1, SRC_RA2;
    logic        STALL;
    logic        MEM_VALID, MEM_KILL, MEM_RFWE, MEM_MEMTOREG;
    logic [4:0]  MEM_WA;
    logic [31:0] MEM_ALUOUT, MEM_RDATA;
    logic        RFWE;
    logic [4:0]  RFWA;
    logic [31:0] RFWD;

    rf_writeback_scoreboard #(.PEND_W(PEND_W), .NREG(32)) dut (
        .CLK(CLK), .RST(RST),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_WE(ISSUE_WE), .ISSUE_WA(ISSUE_WA),
        .SRC_RA1(SRC_RA1), .SRC_RA2(SRC_RA2), .STALL(STALL),
        .MEM_VALID(MEM_VALID), .MEM_KILL(MEM_KILL), .MEM_RFWE(MEM_RFWE),
        .MEM_MEMTOREG(MEM_MEMTOREG), .MEM_WA(MEM_WA),
        .MEM_ALUOUT(MEM_ALUOUT), .MEM_RDATA(MEM_RDATA),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: number of outstanding writes per register and the
    // write that the WB stage is expected to hold.
    int          cnt_m [32];
    bit          m_we, m_ret;
    logic [4:0]  m_wa, m_ret_wa;
    logic [31:0] m_wd;
    bit          use_q;
    logic [4:0]  inflight [$];
    bit          last_stall;

    typedef struct {
        bit          v, k, we, m2r;
        logic [4:0]  wa;
        logic [31:0] alu, rd;
        bit          e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) cnt_m[i] = 0;
        m_we = 0; m_ret = 0; m_wa = '0; m_ret_wa = '0; m_wd = '0;
    endtask

    function automatic bit mbusy(input logic [4:0] r);
        if (r == 0 || cnt_m[r] == 0) return 1'b0;
        if (BYP && m_we && m_wa == r && cnt_m[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_stall();
        if (!ISSUE_VALID) return 1'b0;
        return mbusy(SRC_RA1) || mbusy(SRC_RA2) || (ISSUE_WE && cnt_m[ISSUE_WA] == CMAX);
    endfunction

    task automatic idle();
        ISSUE_VALID = 0; ISSUE_WE = 0; ISSUE_WA = '0; SRC_RA1 = '0; SRC_RA2 = '0;
        MEM_VALID = 0; MEM_KILL = 0; MEM_RFWE = 0; MEM_MEMTOREG = 0;
        MEM_WA = '0; MEM_ALUOUT = '0; MEM_RDATA = '0;
    endtask

    task automatic iss(input bit v, input bit we, input logic [4:0] wa,
                       input logic [4:0] ra1, input logic [4:0] ra2);
        ISSUE_VALID = v; ISSUE_WE = we; ISSUE_WA = wa; SRC_RA1 = ra1; SRC_RA2 = ra2;
    endtask

    task automatic mem(input bit v, input bit k, input bit we, input bit m2r,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] rd);
        MEM_VALID = v; MEM_KILL = k; MEM_RFWE = we; MEM_MEMTOREG = m2r;
        MEM_WA = wa; MEM_ALUOUT = alu; MEM_RDATA = rd;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the
    // rising edge, return 1 time unit after it so the caller can drive inputs.
    task automatic step();
        bit exp_st, acc, ret;
        @(negedge CLK);
        exp_st     = model_stall();
        last_stall = STALL;
        chk("stall", STALL, exp_st);
        chk("rfwe", RFWE, m_we);
        chk("rfwa", RFWA, m_wa);
        chk("rfwd", RFWD, m_wd);
        acc = ISSUE_VALID && !exp_st && ISSUE_WE && ISSUE_WA != 0;
        ret = m_ret && m_ret_wa != 0;
        @(posedge CLK);
        if (acc) cnt_m[ISSUE_WA] = cnt_m[ISSUE_WA] + 1;
        if (ret) cnt_m[m_ret_wa] = cnt_m[m_ret_wa] - 1;
        if (acc && use_q) inflight.push_back(ISSUE_WA);
        m_we     = MEM_VALID && MEM_RFWE && !MEM_KILL && MEM_WA != 0;
        m_wa     = MEM_WA;
        m_wd     = MEM_MEMTOREG ? MEM_RDATA : MEM_ALUOUT;
        m_ret    = MEM_VALID && MEM_RFWE;
        m_ret_wa = MEM_WA;
        #1;
    endtask

    initial begin
        logic [4:0] wa;
        use_q = 0;
        vecs[0] = '{1, 0, 1, 0, 5'd3,  32'h12345678, 32'h00000000, 1, 5'd3,  32'h12345678};
        vecs[1] = '{1, 0, 1, 1, 5'd3,  32'h00000000, 32'hDEADBEEF, 1, 5'd3,  32'hDEADBEEF};
        vecs[2] = '{1, 1, 1, 0, 5'd9,  32'hAAAA5555, 32'h0F0F0F0F, 0, 5'd9,  32'hAAAA5555};
        vecs[3] = '{0, 0, 1, 0, 5'd5,  32'h11111111, 32'h0,        0, 5'd5,  32'h11111111};
        vecs[4] = '{1, 0, 0, 1, 5'd6,  32'h0,        32'h22222222, 0, 5'd6,  32'h22222222};
        vecs[5] = '{1, 0, 1, 0, 5'd0,  32'h33333333, 32'h0,        0, 5'd0,  32'h33333333};
        vecs[6] = '{1, 0, 1, 1, 5'd31, 32'h0,        32'hCAFEF00D, 1, 5'd31, 32'hCAFEF00D};

        // Power-on reset
        idle();
        RST = 1'b1;
        model_reset();
        @(negedge CLK);
        chk("por_rfwe", RFWE, 0);
        chk("por_rfwa", RFWA, 0);
        chk("por_rfwd", RFWD, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Asynchronous reset mid-cycle with r5 pending and r6 in WB
        idle(); iss(1, 1, 6, 0, 0); step();
        idle(); iss(1, 1, 5, 0, 0); mem(1, 0, 1, 0, 6, 32'h5A5A5A5A, 0); step();
        chk("pre_rst_we", RFWE, 1);
        idle(); iss(1, 0, 0, 5, 5);
        #2;
        chk("pre_rst_stall", STALL, 1);
        RST = 1'b1;
        #1;
        chk("rst_we", RFWE, 0);
        chk("rst_wd", RFWD, 0);
        chk("rst_stall", STALL, 0);
        model_reset();
        idle();
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        iss(1, 0, 0, 5, 0); step();
        chk("post_rst_stall", last_stall, 0);

        // WB datapath vectors; a write-issue precedes every retiring row
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].v && vecs[i].we && vecs[i].wa != 0) begin
                idle(); iss(1, 1, vecs[i].wa, 0, 0); step();
            end
            idle();
            mem(vecs[i].v, vecs[i].k, vecs[i].we, vecs[i].m2r, vecs[i].wa, vecs[i].alu, vecs[i].rd);
            step();
            chk($sformatf("vec%0d_we", i), RFWE, vecs[i].e_we);
            chk($sformatf("vec%0d_wa", i), RFWA, vecs[i].e_wa);
            chk($sformatf("vec%0d_wd", i), RFWD, vecs[i].e_wd);
        end
        idle(); step();

        // RAW on r7
        idle(); iss(1, 1, 7, 0, 0); step();
        chk("raw_acc", last_stall, 0);
        idle(); iss(1, 0, 0, 7, 0); step();
        chk("raw_hold1", last_stall, 1);
        step();
        chk("raw_hold2", last_stall, 1);
        mem(1, 0, 1, 0, 7, 32'h77777777, 0); step();
        chk("raw_mem", last_stall, 1);
        idle(); iss(1, 0, 0, 7, 0); step();
        chk("raw_commit", last_stall, BYP ? 0 : 1);
        step();
        chk("raw_after", last_stall, 0);

        // Register 0 never counts, never writes, never stalls
        idle(); iss(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r0_issue", last_stall, 0);
        end
        idle(); iss(1, 0, 0, 3, 0); mem(1, 0, 1, 0, 0, 32'h00001234, 0); step();
        chk("r0_src", last_stall, 0);
        idle(); step();
        chk("r0_we", RFWE, 0);

        // Kill plus simultaneous accept/retire on r9
        idle(); iss(1, 1, 9, 0, 0); step();
        idle(); iss(1, 1, 9, 0, 0); mem(1, 1, 1, 0, 9, 32'h99999999, 0); step();
        chk("kill_we", RFWE, 0);
        chk("kill_wa", RFWA, 9);
        idle(); iss(1, 1, 9, 0, 0); step();
        chk("same_acc", last_stall, 0);
        idle(); iss(1, 0, 0, 9, 0); step();
        chk("k_busy0", last_stall, 1);
        mem(1, 0, 1, 0, 9, 32'h1, 0); step();
        chk("k_busy1", last_stall, 1);
        mem(1, 0, 1, 0, 9, 32'h2, 0); step();
        chk("k_busy2", last_stall, 1);
        idle(); iss(1, 0, 0, 9, 0); step();
        chk("k_last_commit", last_stall, BYP ? 0 : 1);
        step();
        chk("k_free", last_stall, 0);

        // Saturation on r4
        for (int i = 0; i < CMAX; i++) begin
            idle(); iss(1, 1, 4, 0, 0); step();
            chk("sat_fill", last_stall, 0);
        end
        idle(); iss(1, 1, 4, 0, 0); step();
        chk("sat_full1", last_stall, 1);
        step();
        chk("sat_full2", last_stall, 1);
        mem(1, 0, 1, 0, 4, 32'h44444444, 0); step();
        chk("sat_mem", last_stall, 1);
        idle(); iss(1, 1, 4, 0, 0); step();
        chk("sat_commit", last_stall, 1);
        step();
        chk("sat_release", last_stall, 0);
        for (int i = 0; i < CMAX; i++) begin
            idle(); mem(1, 0, 1, 1, 4, 0, 32'h40 + i); step();
        end
        idle(); step(); step();

        // Randomized traffic; accepted writes retire in order from a queue
        use_q = 1;
        inflight.delete();
        for (int n = 0; n < 3000; n++) begin
            idle();
            iss($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
                wa = inflight.pop_front();
                mem(1, $urandom_range(0, 3) == 0, 1, 1'($urandom_range(0, 1)), wa, $urandom, $urandom);
            end else begin
                case ($urandom_range(0, 2))
                    0: mem(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 31)), $urandom, $urandom);
                    1: mem(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 31)), $urandom, $urandom);
                    default: mem(1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
                                 5'd0, $urandom, $urandom);
                endcase
            end
            step();
        end
        use_q = 0;
        while (inflight.size() > 0) begin
            idle();
            wa = inflight.pop_front();
            mem(1, 0, 1, 0, wa, $urandom, $urandom);
            step();
        end
        idle(); step(); step();
        for (int r = 1; r < 8; r++) begin
            idle(); iss(1, 1, 5'(r), 5'(r), 5'(r)); step();
            chk("drained", last_stall, 0);
        end
        idle(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_writeback_scoreboard.md
Name: rf_writeback_scoreboard

Overview:
Writer side of the register file: holds the MEM/WB pipeline register and drives the RF write port (RFWE, RFWA, RFWD) from the memory-stage result. It also keeps a per-register scoreboard of in-flight writes and drives a read-after-write STALL to decode. The write port outputs connect directly to the register file's write inputs.

Parameters:
PEND_W, 2, width of each per-register pending-write counter; saturates at 2^PEND_W-1
NREG, 32, number of architectural registers; register 0 is hardwired zero

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
ISSUE_VALID  in  1  decode presents an instruction this cycle
ISSUE_WE  in  1  issuing instruction writes a register
ISSUE_WA  in  5  destination register of issuing instruction
SRC_RA1  in  5  source register 1 of issuing instruction
SRC_RA2  in  5  source register 2 of issuing instruction
STALL  out  1  combinational; decode must hold the instruction
MEM_VALID  in  1  memory stage holds a live instruction
MEM_KILL  in  1  instruction was squashed; retire its pending count without writing
MEM_RFWE  in  1  instruction writes a register
MEM_MEMTOREG  in  1  1 = select MEM_RDATA, 0 = select MEM_ALUOUT
MEM_WA  in  5  destination register
MEM_ALUOUT  in  32  ALU result
MEM_RDATA  in  32  data memory read result
RFWE  out  1  registered RF write enable
RFWA  out  5  registered RF write address
RFWD  out  32  registered RF write data

Behaviour:
- Reset, asynchronous on RST high: RFWE=0, RFWA=0, RFWD=0, WB valid/kill flags=0, all pending counters=0. While RST is high, STALL=0. Reset mid-operation discards every in-flight write.
- WB register: loads every rising CLK edge with no enable.
  - RFWD <= MEM_MEMTOREG ? MEM_RDATA : MEM_ALUOUT
  - RFWA <= MEM_WA
  - RFWE <= MEM_VALID & MEM_RFWE & ~MEM_KILL & (MEM_WA!=0)
  - Latency is one cycle from MEM inputs to RF write port.
- Retire event: the WB register holds MEM_VALID=1 with MEM_RFWE=1, killed or not. Address is the latched MEM_WA. Retires to register 0 are ignored.
- Issue accept: accept = ISSUE_VALID & ~STALL & ISSUE_WE & (ISSUE_WA!=0).
- Counter update each edge, for cnt[r] with r != 0:
  - +1 on accept to r.
  - -1 on retire of r.
  - Accept and retire to the same r in the same cycle: counter unchanged.
  - cnt[0] is always 0.
- busy(r) = (r!=0) & (cnt[r]!=0).
- STALL = ISSUE_VALID & ( busy(SRC_RA1) | busy(SRC_RA2) | (ISSUE_WE & cnt[ISSUE_WA]==max) ).
  - The saturation term prevents counter overflow.
  - ISSUE_VALID=0 gives STALL=0.
- Retire with the counter already at 0 is a protocol error: the counter stays at 0 (no wrap) and a simulation-only $error is raised.
- Decode guarantees that every accepted write-issue reaches WB exactly once with MEM_RFWE=1, either normally or with MEM_KILL=1.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: STALL ignores a source register r when that register's only pending write is committing this cycle, i.e. RFWE=1, RFWA==r and cnt[r]==1. The RF's combinational write-through supplies the value.
- Not defined: STALL holds until cnt[r]==0, one cycle later.
- The saturation rule is unchanged in both modes.

Test Plan:
- Reset: assert RST asynchronously mid-cycle with cnt[5]=1 -> RFWE=0, RFWD=0 immediately; after release, issue reading r5 gives STALL=0.
- Basic write: MEM_VALID=1, MEM_RFWE=1, MEM_WA=3, MEM_MEMTOREG=0, MEM_ALUOUT=0x12345678 -> next cycle RFWE=1, RFWA=3, RFWD=0x12345678; with MEM_MEMTOREG=1 and MEM_RDATA=0xDEADBEEF, RFWD=0xDEADBEEF.
- RAW stall: accept write-issue to r7, then issue with SRC_RA1=7 -> STALL=1 until the edge after r7 commits (without bypass); STALL drops one cycle earlier with WB_BYPASS_EN defined.
- Register 0: issue with ISSUE_WA=0 and MEM_WA=0 -> no counter change, RFWE stays 0, SRC_RA2=0 never stalls.
- Kill and simultaneous events: accept to r9 while a killed r9 retires in the same cycle -> cnt[9] unchanged, RFWE=0 for the killed slot.
- Saturation: with PEND_W=2, three accepted issues to r4 -> cnt[4]=3; a fourth issue with ISSUE_WE=1, ISSUE_WA=4 gives STALL=1 until one r4 retire.
